// File: rtl/full_adder_pkg.sv
// Shared constants and parameter-legality helper for the full_adder block.
// Defaults and limits live here so the top and any integrator see the same values.
package full_adder_pkg;

    localparam int FA_WIDTH_DEF = 1;
    localparam int FA_PIPE_DEF  = 1;
    localparam int FA_WIDTH_MAX = 32;
    localparam int FA_PIPE_MAX  = 4;

    function automatic bit fa_params_legal(input int width, input int pipe_stages);
        return (width >= 1) && (width <= FA_WIDTH_MAX) &&
               (pipe_stages >= 0) && (pipe_stages <= FA_PIPE_MAX);
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full-adder cell; the top chains WIDTH of these into a ripple adder.
// Plain logic operators are used so X/Z on any input reaches the outputs.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    // Sum and carry of a single bit position
    always_comb begin
        s     = a ^ b ^ c_in;
        c_out = (a & b) | (c_in & (a ^ b));
    end

endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder with an optional output register chain of
// PIPE_STAGES levels carrying {c_out, s} together; 0 stages is fully combinational.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH       = FA_WIDTH_DEF,
    parameter int PIPE_STAGES = FA_PIPE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] s,
    output logic             c_out
);

    logic [WIDTH:0]   carry_s;
    logic [WIDTH-1:0] sum_s;
    logic [WIDTH:0]   result_s;

    generate
        if (!fa_params_legal(WIDTH, PIPE_STAGES)) begin : g_bad_params
            $error("full_adder: WIDTH=%0d / PIPE_STAGES=%0d out of range", WIDTH, PIPE_STAGES);
        end
    endgenerate

    assign carry_s[0] = c_in;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            full_adder_cell u_cell (
                .a     (a[i]),
                .b     (b[i]),
                .c_in  (carry_s[i]),
                .s     (sum_s[i]),
                .c_out (carry_s[i+1])
            );
        end
    endgenerate

    assign result_s = {carry_s[WIDTH], sum_s};

    generate
        if (PIPE_STAGES == 0) begin : g_comb
            // Clock and reset are intentionally inert in the combinational build
            logic unused_s;
            assign unused_s     = clk ^ rst;
            assign {c_out, s}   = result_s;
        end else begin : g_pipe
            logic [WIDTH:0] pipe_r [PIPE_STAGES];

            // Output register chain; reset clears every stage so in-flight results are dropped
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k < PIPE_STAGES; k++) begin
                        pipe_r[k] <= {(WIDTH+1){1'b0}};
                    end
                end else begin
                    pipe_r[0] <= result_s;
                    for (int k = 1; k < PIPE_STAGES; k++) begin
                        pipe_r[k] <= pipe_r[k-1];
                    end
                end
            end

            assign {c_out, s} = pipe_r[PIPE_STAGES-1];
        end
    endgenerate

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder: four configurations share one clock; stimulus
// pushes expected sums (plain integer addition) and a negedge monitor compares.
module tb_full_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // id 0: W1/P1, id 1: W8/P2, id 2: W4/P3, id 3: W4/P0
    logic       rst1, rst8, rst4, rst0;
    logic       a1, b1, c1, s1, co1;
    logic [7:0] a8, b8, s8;
    logic       c8, co8;
    logic [3:0] a4, b4, s4;
    logic       c4, co4;
    logic [3:0] a0, b0, s0;
    logic       c0, co0;

    full_adder #(.WIDTH(1), .PIPE_STAGES(1)) u_w1p1 (.clk(clk), .rst(rst1), .a(a1), .b(b1), .c_in(c1), .s(s1), .c_out(co1));
    full_adder #(.WIDTH(8), .PIPE_STAGES(2)) u_w8p2 (.clk(clk), .rst(rst8), .a(a8), .b(b8), .c_in(c8), .s(s8), .c_out(co8));
    full_adder #(.WIDTH(4), .PIPE_STAGES(3)) u_w4p3 (.clk(clk), .rst(rst4), .a(a4), .b(b4), .c_in(c4), .s(s4), .c_out(co4));
    full_adder #(.WIDTH(4), .PIPE_STAGES(0)) u_w4p0 (.clk(clk), .rst(rst0), .a(a0), .b(b0), .c_in(c0), .s(s0), .c_out(co0));

    typedef struct {
        int          id;
        int          due;
        logic [32:0] val;
    } exp_t;

    exp_t  sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    string names [4] = '{"w1p1", "w8p2", "w4p3", "w4p0"};
    int    pipe  [4] = '{1, 2, 3, 0};
    int    width [4] = '{1, 8, 4, 4};

    function automatic logic [32:0] actual(input int id);
        case (id)
            0:       return {31'd0, co1, s1};
            1:       return {24'd0, co8, s8};
            2:       return {28'd0, co4, s4};
            3:       return {28'd0, co0, s0};
            default: return 33'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int id, input int due, input logic [32:0] val);
        exp_t e;
        e.id  = id;
        e.due = due;
        e.val = val;
        sb.push_back(e);
    endtask

    // Apply one operand set to a DUT and record the reference sum
    task automatic drive(input int id, input logic [31:0] av, input logic [31:0] bv, input logic cv);
        logic [32:0] mask;
        logic [32:0] sum;
        mask = (33'd1 << width[id]) - 33'd1;
        sum  = ({1'b0, av} & mask) + ({1'b0, bv} & mask) + {32'd0, cv};
        case (id)
            0: begin a1 = av[0];   b1 = bv[0];   c1 = cv; end
            1: begin a8 = av[7:0]; b8 = bv[7:0]; c8 = cv; end
            2: begin a4 = av[3:0]; b4 = bv[3:0]; c4 = cv; end
            default: begin a0 = av[3:0]; b0 = bv[3:0]; c0 = cv; end
        endcase
        push(id, cyc + pipe[id], sum);
    endtask

    // Monitor: retire every scoreboard entry due this cycle
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                check(names[sb[i].id], actual(sb[i].id), sb[i].val);
                sb.delete(i);
            end else if (sb[i].due < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s stale: entry due %0d not retired by %0d", names[sb[i].id], sb[i].due, cyc);
                sb.delete(i);
            end
        end
    end

    initial begin
        rst1 = 1'b0; rst8 = 1'b0; rst4 = 1'b0; rst0 = 1'b0;
        a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        a8 = 8'd0; b8 = 8'd0; c8 = 1'b0;
        a4 = 4'd0; b4 = 4'd0; c4 = 1'b0;
        a0 = 4'd0; b0 = 4'd0; c0 = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int id = 0; id < 3; id++) check({names[id], " reset"}, actual(id), 33'd0);

        // Release and stream back-to-back vectors into every configuration
        @(posedge clk); #1;
        rst1 = 1'b1; rst8 = 1'b1; rst4 = 1'b1; rst0 = 1'b1;
        for (int id = 0; id < 4; id++)
            for (int j = 0; j < pipe[id]; j++) push(id, cyc + j, 33'd0);
        for (int k = 0; k < 30; k++) begin
            logic [2:0] sw;
            if (k > 0) begin
                @(posedge clk); #1;
            end
            sw = k[2:0];
            if (k < 8) drive(0, {31'd0, sw[2]}, {31'd0, sw[1]}, sw[0]);
            else       drive(0, $urandom, $urandom, 1'($urandom));
            if (k == 0)      drive(1, 32'hFF, 32'h01, 1'b0);
            else if (k == 1) drive(1, 32'hFF, 32'hFF, 1'b1);
            else             drive(1, $urandom, $urandom, 1'($urandom));
            drive(2, $urandom, $urandom, 1'($urandom));
            if (k == 0) drive(3, 32'd5, 32'd3, 1'b1);
            else        drive(3, $urandom, $urandom, 1'($urandom));
        end
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("drain stream", 33'(sb.size()), 33'd0);

        // W1/P1 reset pulse: low 2 periods, high 1 period with 1,1,1, low again
        @(posedge clk); #1;
        rst1 = 1'b0; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        #1 check("w1p1 rst assert", actual(0), 33'd0);
        repeat (2) begin
            @(negedge clk);
            check("w1p1 rst low", actual(0), 33'd0);
        end
        @(posedge clk); #1;
        rst1 = 1'b1;
        push(0, cyc, 33'd0);
        @(posedge clk); #1;
        check("w1p1 after release", actual(0), 33'd3);
        rst1 = 1'b0;
        #1 check("w1p1 rst reassert", actual(0), 33'd0);
        @(negedge clk);
        check("w1p1 rst low again", actual(0), 33'd0);

        // W8/P2 asynchronous reset between edges with a nonzero result in flight
        @(posedge clk); #1;
        a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0;
        repeat (2) @(posedge clk);
        #3 check("w8p2 before async rst", actual(1), 33'h100);
        rst8 = 1'b0;
        #1 check("w8p2 async rst", actual(1), 33'd0);
        @(negedge clk);
        check("w8p2 rst held", actual(1), 33'd0);
        @(posedge clk); #1;
        rst8 = 1'b1;
        push(1, cyc, 33'd0);
        push(1, cyc + 1, 33'd0);
        drive(1, 32'h12, 32'h34, 1'b1);

        // W4/P0: combinational, rst toggling and clock edges have no effect
        a0 = 4'd5; b0 = 4'd3; c0 = 1'b1;
        #1 check("w4p0 comb", actual(3), 33'd9);
        for (int t = 0; t < 4; t++) begin
            rst0 = ~rst0;
            #1 check("w4p0 rst toggle", actual(3), 33'd9);
            @(posedge clk); #1;
            check("w4p0 clk edge", actual(3), 33'd9);
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("drain final", 33'(sb.size()), 33'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
